// File: rtl/dsp_param_sequencer.sv
// Glitch-free parameter sequencer for a dual-channel DSP datapath.
// CSR writes land in shadow registers; a commit snapshots them into targets.
// Phase increments switch on the next decimated-rate strobe.
// Gains then ramp toward their targets by a fixed step on each strobe.
module dsp_param_sequencer #(
  parameter int unsigned PW = 19,
  parameter int unsigned GW = 32
) (
  input  logic          sys_clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [2:0]    wr_addr,
  input  logic [31:0]   wr_data,
  input  logic          commit,
  input  logic          sample_ce,
  input  logic          clr_err,
  output logic [PW-1:0] phase_inc_down,
  output logic [PW-1:0] phase_inc_down1,
  output logic [GW-1:0] gain1,
  output logic [GW-1:0] gain2,
  output logic          busy,
  output logic          update_done,
  output logic          commit_err
);

  typedef enum logic [1:0] {StIdle, StWaitCe, StRamp, StDone} state_e;

  state_e state_q, state_d;

  logic [PW-1:0] sh_ph0, sh_ph1, tgt_ph0, tgt_ph1;
  logic [GW-1:0] sh_g1, sh_g2, sh_step, tgt_g1, tgt_g2, tgt_step;
  logic [PW-1:0] snap_ph0, snap_ph1;
  logic [GW-1:0] snap_g1, snap_g2, snap_step;
  logic          gains_settled;

  // Move cur one step toward tgt; compare first so the sum never wraps.
  function automatic logic [GW-1:0] ramp_next(input logic [GW-1:0] cur,
                                              input logic [GW-1:0] tgt,
                                              input logic [GW-1:0] step);
    logic [GW-1:0] res;
    res = cur;
    if (cur < tgt) begin
      res = ((tgt - cur) > step) ? cur + step : tgt;
    end else if (cur > tgt) begin
      res = ((cur - tgt) > step) ? cur - step : tgt;
    end
    return res;
  endfunction

  // Snapshot sees a write issued in the same cycle as the commit.
  always_comb begin
    snap_ph0  = (wr_en && wr_addr == 3'd0) ? wr_data[PW-1:0] : sh_ph0;
    snap_ph1  = (wr_en && wr_addr == 3'd1) ? wr_data[PW-1:0] : sh_ph1;
    snap_g1   = (wr_en && wr_addr == 3'd2) ? wr_data[GW-1:0] : sh_g1;
    snap_g2   = (wr_en && wr_addr == 3'd3) ? wr_data[GW-1:0] : sh_g2;
    snap_step = (wr_en && wr_addr == 3'd4) ? wr_data[GW-1:0] : sh_step;
  end

  assign gains_settled = (gain1 == tgt_g1) && (gain2 == tgt_g2);

  // Shadow register file, writable in any state.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sh_ph0  <= '0;
      sh_ph1  <= '0;
      sh_g1   <= '0;
      sh_g2   <= '0;
      sh_step <= '0;
    end else if (wr_en) begin
      case (wr_addr)
        3'd0:    sh_ph0  <= wr_data[PW-1:0];
        3'd1:    sh_ph1  <= wr_data[PW-1:0];
        3'd2:    sh_g1   <= wr_data[GW-1:0];
        3'd3:    sh_g2   <= wr_data[GW-1:0];
        3'd4:    sh_step <= wr_data[GW-1:0];
        default: ;
      endcase
    end
  end

  // Next-state logic; RAMP exit is checked every cycle, not only on strobes.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (commit) state_d = StWaitCe;
      StWaitCe: if (sample_ce) state_d = StRamp;
      StRamp:   if (gains_settled) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State register plus registered status flags.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      busy        <= 1'b0;
      update_done <= 1'b0;
      commit_err  <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy        <= (state_d != StIdle);
      update_done <= (state_d == StDone);
      // A fresh error wins over a simultaneous clear.
      if (commit && state_q != StIdle) begin
        commit_err <= 1'b1;
      end else if (clr_err) begin
        commit_err <= 1'b0;
      end
    end
  end

  // Target capture, phase switch-over and gain ramp.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      tgt_ph0         <= '0;
      tgt_ph1         <= '0;
      tgt_g1          <= '0;
      tgt_g2          <= '0;
      tgt_step        <= '0;
      phase_inc_down  <= '0;
      phase_inc_down1 <= '0;
      gain1           <= '0;
      gain2           <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (commit) begin
            tgt_ph0  <= snap_ph0;
            tgt_ph1  <= snap_ph1;
            tgt_g1   <= snap_g1;
            tgt_g2   <= snap_g2;
            tgt_step <= snap_step;
          end
        end
        StWaitCe: begin
          if (sample_ce) begin
            phase_inc_down  <= tgt_ph0;
            phase_inc_down1 <= tgt_ph1;
            // Zero step means jump straight to the targets.
            if (tgt_step == '0) begin
              gain1 <= tgt_g1;
              gain2 <= tgt_g2;
            end
          end
        end
        StRamp: begin
          if (sample_ce) begin
            gain1 <= ramp_next(gain1, tgt_g1, tgt_step);
            gain2 <= ramp_next(gain2, tgt_g2, tgt_step);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_param_sequencer.sv
// Self-checking bench for dsp_param_sequencer: a behavioural model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_dsp_param_sequencer;

  localparam int unsigned PW = 19;
  localparam int unsigned GW = 32;

  logic          sys_clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [2:0]    wr_addr = '0;
  logic [31:0]   wr_data = '0;
  logic          commit = 1'b0;
  logic          sample_ce = 1'b0;
  logic          clr_err = 1'b0;
  logic [PW-1:0] phase_inc_down, phase_inc_down1;
  logic [GW-1:0] gain1, gain2;
  logic          busy, update_done, commit_err;

  int n_checks = 0;
  int n_pass = 0;
  bit run = 1'b0;

  dsp_param_sequencer #(.PW(PW), .GW(GW)) dut (
    .sys_clk         (sys_clk),
    .rst             (rst),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .commit          (commit),
    .sample_ce       (sample_ce),
    .clr_err         (clr_err),
    .phase_inc_down  (phase_inc_down),
    .phase_inc_down1 (phase_inc_down1),
    .gain1           (gain1),
    .gain2           (gain2),
    .busy            (busy),
    .update_done     (update_done),
    .commit_err      (commit_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Parameter set indices: 0 ph0, 1 ph1, 2 g1, 3 g2, 4 step.
  logic [31:0] m_sh [5];
  logic [31:0] m_tg [5];
  logic [PW-1:0] m_ph0, m_ph1;
  logic [31:0] m_g1, m_g2;
  logic m_busy, m_done, m_err;
  int m_phase;  // 0 idle, 1 awaiting strobe, 2 ramping, 3 finishing

  function automatic logic [31:0] snap(input int i);
    if (wr_en && int'(wr_addr) == i) return wr_data;
    return m_sh[i];
  endfunction

  function automatic logic [31:0] step_to(input logic [31:0] cur, input logic [31:0] tgt,
                                          input logic [31:0] st);
    longint c = longint'(cur);
    longint t = longint'(tgt);
    longint s = longint'(st);
    if (c < t) return (t - c > s) ? 32'(c + s) : tgt;
    if (c > t) return (c - t > s) ? 32'(c - s) : tgt;
    return cur;
  endfunction

  always @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        m_sh[i] <= '0;
        m_tg[i] <= '0;
      end
      m_ph0 <= '0; m_ph1 <= '0; m_g1 <= '0; m_g2 <= '0;
      m_busy <= 1'b0; m_done <= 1'b0; m_err <= 1'b0; m_phase <= 0;
    end else begin
      if (wr_en && wr_addr < 3'd5) m_sh[wr_addr] <= wr_data;
      if (commit && m_phase != 0) m_err <= 1'b1;
      else if (clr_err) m_err <= 1'b0;
      m_done <= 1'b0;
      case (m_phase)
        0: if (commit) begin
          for (int i = 0; i < 5; i++) m_tg[i] <= snap(i);
          m_phase <= 1;
          m_busy <= 1'b1;
        end
        1: if (sample_ce) begin
          m_ph0 <= m_tg[0][PW-1:0];
          m_ph1 <= m_tg[1][PW-1:0];
          if (m_tg[4] == 0) begin
            m_g1 <= m_tg[2];
            m_g2 <= m_tg[3];
          end
          m_phase <= 2;
        end
        2: if (m_g1 == m_tg[2] && m_g2 == m_tg[3]) begin
          m_phase <= 3;
          m_done <= 1'b1;
        end else if (sample_ce) begin
          m_g1 <= step_to(m_g1, m_tg[2], m_tg[4]);
          m_g2 <= step_to(m_g2, m_tg[3], m_tg[4]);
        end
        default: begin
          m_phase <= 0;
          m_busy <= 1'b0;
        end
      endcase
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge sys_clk) begin
    if (run) begin
      check("model_ph0", 32'(phase_inc_down), 32'(m_ph0));
      check("model_ph1", 32'(phase_inc_down1), 32'(m_ph1));
      check("model_g1", gain1, m_g1);
      check("model_g2", gain2, m_g2);
      check("model_busy", 32'(busy), 32'(m_busy));
      check("model_done", 32'(update_done), 32'(m_done));
      check("model_err", 32'(commit_err), 32'(m_err));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    cyc();
    commit = 1'b0;
  endtask

  task automatic ce();
    sample_ce = 1'b1;
    cyc();
    sample_ce = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    do_reset();
    run = 1'b1;
    check("rst_g1", gain1, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    // Step-zero update: everything lands together one cycle after the strobe
    wr(3'd0, 32'h0000_1000);
    wr(3'd1, 32'h0000_2000);
    wr(3'd2, 32'h4000_0000);
    wr(3'd3, 32'h4000_0000);
    wr(3'd4, 32'h0);
    do_commit();
    check("t1_busy_after_commit", 32'(busy), 32'h1);
    repeat (4) cyc();
    check("t1_g1_before_ce", gain1, 32'h0);
    ce();
    check("t1_ph0", 32'(phase_inc_down), 32'h0000_1000);
    check("t1_ph1", 32'(phase_inc_down1), 32'h0000_2000);
    check("t1_g1", gain1, 32'h4000_0000);
    check("t1_g2", gain2, 32'h4000_0000);
    cyc();
    check("t1_done", 32'(update_done), 32'h1);
    cyc();
    check("t1_done_low", 32'(update_done), 32'h0);
    check("t1_idle", 32'(busy), 32'h0);

    // Upward ramp 0 -> 0x500 in 0x100 steps
    do_reset();
    wr(3'd2, 32'h0000_0500);
    wr(3'd4, 32'h0000_0100);
    do_commit();
    ce();
    check("t2_g1_load", gain1, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      ce();
      check("t2_g1_step", gain1, 32'(k * 32'h100));
    end
    cyc();
    check("t2_done", 32'(update_done), 32'h1);
    cyc();

    // Downward ramp without underflow, upward clamp at full scale
    wr(3'd2, 32'h0000_0250);
    wr(3'd3, 32'hFFFF_FF80);
    wr(3'd4, 32'h0);
    do_commit();
    ce();
    cyc();
    cyc();
    check("t3_g1_start", gain1, 32'h0000_0250);
    wr(3'd2, 32'h0);
    wr(3'd3, 32'hFFFF_FFFF);
    wr(3'd4, 32'h0000_0100);
    do_commit();
    ce();
    ce();
    check("t3_g1_a", gain1, 32'h0000_0150);
    check("t3_g2_clamp", gain2, 32'hFFFF_FFFF);
    ce();
    check("t3_g1_b", gain1, 32'h0000_0050);
    ce();
    check("t3_g1_c", gain1, 32'h0);
    cyc();
    check("t3_done", 32'(update_done), 32'h1);
    cyc();

    // Commit while busy is dropped and flagged; shadow writes stay hidden
    wr(3'd2, 32'h0000_0300);
    do_commit();
    ce();
    ce();
    check("t4_g1_a", gain1, 32'h0000_0100);
    wr(3'd2, 32'h0000_0800);
    do_commit();
    check("t4_err", 32'(commit_err), 32'h1);
    wr(3'd0, 32'h0000_7777);
    check("t4_ph0_hidden", 32'(phase_inc_down), 32'h0);
    ce();
    ce();
    check("t4_g1_first_target", gain1, 32'h0000_0300);
    cyc();
    check("t4_done", 32'(update_done), 32'h1);
    cyc();
    check("t4_err_sticky", 32'(commit_err), 32'h1);
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    check("t4_err_cleared", 32'(commit_err), 32'h0);
    do_commit();
    check("t4_recommit_busy", 32'(busy), 32'h1);
    ce();
    check("t4_ph0_new", 32'(phase_inc_down), 32'h0000_7777);
    repeat (5) ce();
    check("t4_g1_new", gain1, 32'h0000_0800);
    cyc();
    cyc();

    // Asynchronous reset mid-ramp, then a fresh commit on the first edge
    do_reset();
    wr(3'd2, 32'h0000_0500);
    wr(3'd4, 32'h0000_0100);
    do_commit();
    repeat (4) ce();
    check("t5_g1_mid", gain1, 32'h0000_0300);
    rst = 1'b1;
    #2;
    check("t5_rst_g1", gain1, 32'h0);
    check("t5_rst_busy", 32'(busy), 32'h0);
    check("t5_rst_done", 32'(update_done), 32'h0);
    rst = 1'b0;
    wr(3'd4, 32'h0000_0100);
    // Write and commit in the same cycle: snapshot takes the new value
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'h0000_0200; commit = 1'b1;
    cyc();
    wr_en = 1'b0; commit = 1'b0;
    check("t5_busy", 32'(busy), 32'h1);
    repeat (3) ce();
    check("t5_g1", gain1, 32'h0000_0200);
    cyc();
    check("t5_done", 32'(update_done), 32'h1);
    cyc();
    cyc();

    run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
